// File: rtl/if_prefetch_stage.sv
// ============================================================================
// Module   : if_prefetch_stage
// Function : Instruction fetch with PC generation, one-cycle synchronous
//            instruction-memory interface, DEPTH-entry prefetch FIFO,
//            valid/ready delivery to ID and redirect with flush.
// Options  : IF_PERF_CNT_EN adds saturating fetch/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_prefetch_stage #(
  parameter int              PC_W        = 8,
  parameter int              IW          = 32,
  parameter int              DEPTH       = 4,
  parameter int              INSTR_BYTES = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            res_n,
  output logic [PC_W-1:0] i_addr,
  output logic            i_req,
  input  logic [IW-1:0]   i_datain,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [IW-1:0]   if_instr,
  output logic [PC_W-1:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int              c_PTR_W      = $clog2(DEPTH);
  localparam int              c_CNT_W      = c_PTR_W + 1;
  localparam logic [PC_W-1:0] c_PC_INC     = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] c_ALIGN_MASK = ~(PC_W'(INSTR_BYTES - 1));
  localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_req_addr;
  logic               r_inflight;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic [IW-1:0]      r_fifo_instr [DEPTH];
  logic [PC_W-1:0]    r_fifo_pc    [DEPTH];

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_req;
  logic [c_CNT_W:0]   w_occupancy;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && if_ready;

  // Credit check: entries left after this cycle's pop plus the one in flight.
  assign w_occupancy = {1'b0, r_count} - (c_CNT_W + 1)'(w_pop)
                     + (c_CNT_W + 1)'(r_inflight);
  assign w_req  = !res_n && !redirect_valid && (w_occupancy < c_DEPTH_EXT);
  assign w_push = !res_n && r_inflight && !redirect_valid;

  assign i_addr = r_pc;
  assign i_req  = w_req;

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc & c_ALIGN_MASK;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + c_PC_INC;
      end
    end
  end

  // Redirect clears the queue outright; a coincident pop needs no bookkeeping.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_tail] <= i_datain;
      r_fifo_pc[r_tail]    <= r_req_addr;
    end
  end

  assign if_valid = w_valid;
  assign if_instr = w_valid ? r_fifo_instr[r_head] : '0;
  assign if_pc    = w_valid ? r_fifo_pc[r_head]    : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_req && (r_perf_fetch != 32'hFFFF_FFFF)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_valid && !if_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
// ============================================================================
// Module   : tb_if_prefetch_stage
// Function : Directed self-checking bench for if_prefetch_stage; memory model
//            returns 0x1000_0000 | addr one cycle after each address.
// Options  : IF_PERF_CNT_EN enables the performance-counter scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_prefetch_stage;

  localparam int PC_W  = 8;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            res_n;
  logic [PC_W-1:0] i_addr;
  logic            i_req;
  logic [IW-1:0]   i_datain;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [IW-1:0]   if_instr;
  logic [PC_W-1:0] if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_fetch_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .PC_W(PC_W), .IW(IW), .DEPTH(DEPTH), .INSTR_BYTES(4), .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .res_n(res_n),
    .i_addr(i_addr),
    .i_req(i_req),
    .i_datain(i_datain),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Synchronous instruction memory: data for the current address next cycle.
  always @(posedge clk) begin
    i_datain <= 32'h1000_0000 | 32'(i_addr);
  end

  always @(posedge clk) begin
    if (!res_n) begin
      assert (!(dut.w_push && !dut.w_pop && dut.r_count == 3'(DEPTH)))
      else begin
        failures = failures + 1;
        $display("FAIL fifo_overflow: push into full FIFO, count=%0d required<%0d", dut.r_count, DEPTH);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release(input logic ready);
    res_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    next_cycle();
    next_cycle();
    res_n    = 1'b0;
    if_ready = ready;
    #1;
  endtask

  task automatic test_reset();
    res_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (i_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0h required 0", i_req); end
    checks++;
    if (i_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %0h required 00", i_addr); end
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h required 0", if_valid); end
    checks++;
    if (if_instr !== 32'h0 || if_pc !== 8'h00) begin
      failures++; $display("FAIL reset_head: got instr=%h pc=%h required 0/0", if_instr, if_pc);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] pc;
    next_cycle();
    res_n = 1'b0;
    #1;
    checks++;
    if (i_req !== 1'b1 || i_addr !== 8'h00) begin
      failures++; $display("FAIL stream_first_req: got req=%0h addr=%h required 1/00", i_req, i_addr);
    end
    next_cycle();
    checks++;
    if (if_valid !== 1'b0 || i_addr !== 8'h04) begin
      failures++; $display("FAIL stream_cycle2: got valid=%0h addr=%h required 0/04", if_valid, i_addr);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      pc = 8'(k * 4);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== pc || if_instr !== (32'h1000_0000 | 32'(pc))) begin
        failures++;
        $display("FAIL stream_deliver: got valid=%0h pc=%h instr=%h required 1/%h/%h",
                 if_valid, if_pc, if_instr, pc, 32'h1000_0000 | 32'(pc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] pc;
    int              reqs;
    reset_release(1'b0);
    reqs = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      if (i_req === 1'b1) begin
        checks++;
        pc = 8'(reqs * 4);
        if (i_addr !== pc) begin
          failures++; $display("FAIL bp_req_addr: got %h required %h", i_addr, pc);
        end
        reqs++;
      end
      if (c >= 3) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 32'h1000_0000) begin
          failures++;
          $display("FAIL bp_hold: cycle %0d got valid=%0h pc=%h instr=%h required 1/00/10000000",
                   c, if_valid, if_pc, if_instr);
        end
      end
    end
    checks++;
    if (reqs != 4) begin failures++; $display("FAIL bp_req_count: got %0d required 4", reqs); end
    next_cycle();
    if_ready = 1'b1;
    #1;
    checks++;
    if (i_req !== 1'b1 || i_addr !== 8'h10) begin
      failures++; $display("FAIL bp_resume_req: got req=%0h addr=%h required 1/10", i_req, i_addr);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
      pc = 8'(k * 4);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== pc) begin
        failures++; $display("FAIL bp_drain: got valid=%0h pc=%h required 1/%h", if_valid, if_pc, pc);
      end
    end
  endtask

  task automatic test_redirect();
    reset_release(1'b1);
    next_cycle();
    next_cycle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00) begin
      failures++; $display("FAIL redir_setup0: got valid=%0h pc=%h required 1/00", if_valid, if_pc);
    end
    next_cycle();
    next_cycle();
    if_ready = 1'b0;
    #1;
    checks++;
    if (if_pc !== 8'h08 || i_req !== 1'b1 || i_addr !== 8'h10) begin
      failures++; $display("FAIL redir_setup: got pc=%h req=%0h addr=%h required 08/1/10", if_pc, i_req, i_addr);
    end
    next_cycle();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h43;
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h08 || if_instr !== 32'h1000_0008 || i_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_pop: got valid=%0h pc=%h instr=%h req=%0h required 1/08/10000008/0",
               if_valid, if_pc, if_instr, i_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 8'h40) begin
      failures++; $display("FAIL redir_fetch: got valid=%0h req=%0h addr=%h required 0/1/40", if_valid, i_req, i_addr);
    end
    next_cycle();
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flushed: got valid=%0h pc=%h required 0", if_valid, if_pc); end
    next_cycle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h40 || if_instr !== 32'h1000_0040) begin
      failures++; $display("FAIL redir_target: got valid=%0h pc=%h instr=%h required 1/40/10000040", if_valid, if_pc, if_instr);
    end
    next_cycle();
    checks++;
    if (if_pc !== 8'h44) begin failures++; $display("FAIL redir_next: got pc=%h required 44", if_pc); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    next_cycle();
    redirect_pc    = 8'h21;
    #1;
    checks++;
    if (i_req !== 1'b0) begin failures++; $display("FAIL b2b_noreq: got %0h required 0", i_req); end
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (i_req !== 1'b1 || i_addr !== 8'h20 || if_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_latest: got req=%0h addr=%h valid=%0h required 1/20/0", i_req, i_addr, if_valid);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h20) begin
      failures++; $display("FAIL b2b_deliver: got valid=%0h pc=%h required 1/20", if_valid, if_pc);
    end
  endtask

  task automatic test_pc_wrap();
    logic [PC_W-1:0] exp_pc [4];
    exp_pc[0] = 8'hF8;
    exp_pc[1] = 8'hFC;
    exp_pc[2] = 8'h00;
    exp_pc[3] = 8'h04;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 8'hF8;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (i_addr !== 8'hF8) begin failures++; $display("FAIL wrap_fetch: got %h required F8", i_addr); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[k] || if_instr !== (32'h1000_0000 | 32'(exp_pc[k]))) begin
        failures++;
        $display("FAIL wrap_deliver: got valid=%0h pc=%h instr=%h required 1/%h", if_valid, if_pc, if_instr, exp_pc[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    next_cycle();
    #2;
    res_n = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || i_req !== 1'b0) begin
      failures++; $display("FAIL areset_immediate: got valid=%0h req=%0h required 0/0", if_valid, i_req);
    end
    #2;
    res_n = 1'b0;
    #1;
    checks++;
    if (i_req !== 1'b1 || i_addr !== 8'h00 || if_valid !== 1'b0) begin
      failures++; $display("FAIL areset_restart: got req=%0h addr=%h valid=%0h required 1/00/0", i_req, i_addr, if_valid);
    end
    next_cycle();
    checks++;
    if (if_valid !== 1'b0) begin
      failures++; $display("FAIL areset_stale: got valid=%0h pc=%h required 0", if_valid, if_pc);
    end
    next_cycle();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 32'h1000_0000) begin
      failures++; $display("FAIL areset_first: got valid=%0h pc=%h instr=%h required 1/00/10000000", if_valid, if_pc, if_instr);
    end
    next_cycle();
    checks++;
    if (if_pc !== 8'h04) begin failures++; $display("FAIL areset_second: got pc=%h required 04", if_pc); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    reset_release(1'b0);
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_start: got %0d/%0d required 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
    for (int c = 2; c <= 12; c++) begin
      next_cycle();
      if_ready = (c >= 6);
      #1;
    end
    checks++;
    if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd3) begin
      failures++; $display("FAIL perf_counts: got fetch=%0d stall=%0d required 10/3", perf_fetch_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    res_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised successor to the original fetch stage: generates the PC, issues requests to a synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO.
- Delivers instructions to ID over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of the queue and of any in-flight fetch.
- Sits between instruction memory and the ID stage in the pipelined core.

Parameters:
- PC_W, 8, PC and instruction-address width in bits.
- IW, 32, instruction width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- INSTR_BYTES, 4, PC increment per instruction; power of two.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- res_n  in  1  asynchronous, active-high reset (asserted = 1) despite the name.
- i_addr  out  PC_W  fetch address; valid when i_req = 1.
- i_req  out  1  fetch request; memory returns data exactly one cycle later.
- i_datain  in  IW  instruction data for the request issued in the previous cycle.
- redirect_valid  in  1  one-cycle redirect strobe from EX.
- redirect_pc  in  PC_W  redirect target.
- if_valid  out  1  FIFO head holds a valid instruction.
- if_ready  in  1  ID accepts the head.
- if_instr  out  IW  head instruction; 0 when if_valid = 0.
- if_pc  out  PC_W  PC of head instruction; 0 when if_valid = 0.

Behaviour:
- Reset (async, res_n = 1) forces:
  - pc = RESET_PC, i_addr = RESET_PC, i_req = 0.
  - FIFO empty, count = 0, inflight = 0, if_valid = 0, if_instr = 0, if_pc = 0.
  - All perf counters = 0.
  - Reset asserted mid-operation discards everything immediately; a response arriving after reset release is ignored because inflight = 0.
- i_addr = pc (combinational from the pc register).
- Issue rule:
  - i_req = !redirect_valid && (count - pop + inflight < DEPTH), where pop = if_valid && if_ready.
  - On issue: inflight <= 1, pc <= pc + INSTR_BYTES, modulo 2^PC_W (wraps 0xFC -> 0x00 at PC_W = 8).
  - When no request issues, inflight <= 0.
- Capture: when inflight = 1 and no redirect this cycle, {i_addr of that request, i_datain} is written at the FIFO tail at the clock edge.
- Latency: request in cycle N -> data on i_datain in N+1 -> if_valid in N+2.
- Throughput: with if_ready held at 1, one instruction per cycle for any DEPTH >= 2.
- FIFO:
  - Head/tail pointers of log2(DEPTH) bits, wrapping naturally; count of log2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible by the credit rule; a push when full is a design error and is checked by a bench assertion.
- Handshake: the head is consumed on a rising edge with if_valid && if_ready. if_valid is never dropped without consumption or redirect; if_instr/if_pc are held stable while if_valid && !if_ready.
- Redirect (highest priority):
  - A pop in the same cycle still completes (ID keeps that instruction).
  - FIFO is then cleared and inflight is cleared, so the response arriving next cycle is dropped.
  - pc <= redirect_pc with its low log2(INSTR_BYTES) bits forced to 0.
  - No request is issued in the redirect cycle; the first fetch of the target is the next cycle.
  - Back-to-back redirects: the latest one wins.
- Only state machine: implicit; inflight is a 1-bit pending flag. No other states.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on every i_req) and perf_stall_cnt[31:0] (increments each cycle with if_valid && !if_ready).
  - Both counters saturate at 0xFFFFFFFF and are reset to 0.
- IF_PERF_CNT_EN undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, if_ready = 1, memory returns instr = 0x1000_0000 | addr:
  - i_req = 1 with i_addr = 0x00 in the first cycle.
  - if_valid in the 3rd cycle with if_pc = 0x00, if_instr = 0x1000_0000.
  - Then one instruction per cycle at PCs 0x04, 0x08, ...
- Backpressure, DEPTH = 4, if_ready = 0:
  - Exactly 4 requests issued (0x00–0x0C), then i_req = 0.
  - if_instr/if_pc stable at 0x00.
  - After if_ready = 1, delivery is in order 0x00, 0x04, 0x08, 0x0C, 0x10 with no gaps or duplicates.
- Redirect to 0x43 while FIFO holds 0x08/0x0C and 0x10 is in flight, with a pop of 0x08 in the same cycle:
  - 0x08 is delivered.
  - 0x0C and 0x10 never appear.
  - Next fetch i_addr = 0x40.
  - if_valid returns 2 cycles later with if_pc = 0x40.
- PC wrap at PC_W = 8: redirect to 0xF8 -> delivered PCs 0xF8, 0xFC, 0x00, 0x04.
- Asynchronous reset pulse mid-stream, asserted between clock edges:
  - if_valid = 0 and i_req = 0 immediately.
  - After release, fetch restarts at RESET_PC; the stale response is not enqueued.
- IF_PERF_CNT_EN defined: 10 fetches with 3 stalled cycles -> perf_fetch_cnt = 10, perf_stall_cnt = 3.
